mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single rwmemory port.
// One access in flight at a time: grant in IDLE, memory access in EXEC, response held in RESP.
module mem_arbiter #(
    parameter  int MEMSIZE = 'h400,
    localparam int AW      = $clog2(MEMSIZE)
) (
    input  logic          clk,
    input  logic          reset_n,
    // fetch port
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rsp_valid,
    output logic [31:0]   i_rsp_data,
    output logic          i_rsp_err,
    input  logic          i_rsp_ready,
    // data port
    input  logic          d_req,
    input  logic          d_wen,
    input  logic [2:0]    d_size,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rsp_valid,
    output logic [31:0]   d_rsp_data,
    output logic          d_rsp_err,
    input  logic          d_rsp_ready,
    // rwmemory port
    output logic          mem_en,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [2:0]    mem_size,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    typedef struct packed {
        logic          owner_d;
        logic          wen;
        logic [2:0]    size;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic          err;
    } cmd_t;

    state_t      r_state;
    logic        r_last_d;
    cmd_t        r_cmd;
    logic [31:0] r_rsp_data;
    logic        r_rsp_err;

    logic        w_idle;
    logic        w_i_gnt;
    logic        w_d_gnt;
    logic        w_exec;
    logic        w_owner_rdy;
    cmd_t        w_new_cmd;
    logic [31:0] w_rd_masked;

    function automatic logic f_illegal(input logic [2:0] size, input logic [AW-1:0] addr);
        logic [31:0] w_end;
        w_end = 32'(addr) + ((size == 3'd0) ? 32'd1 : (size == 3'd1) ? 32'd2 : 32'd4);
        return (size > 3'd2) ||
               ((size == 3'd1) && addr[0]) ||
               ((size == 3'd2) && (addr[1:0] != 2'b00)) ||
               (w_end > 32'(MEMSIZE));
    endfunction

    // Grants are gated by reset so every output is quiet while reset_n is low.
    assign w_idle  = reset_n && (r_state == S_IDLE);
    assign w_i_gnt = w_idle && i_req && (!d_req || r_last_d);
    assign w_d_gnt = w_idle && d_req && (!i_req || !r_last_d);

    always_comb begin
        w_new_cmd = '0;
        if (w_d_gnt) begin
            w_new_cmd.owner_d = 1'b1;
            w_new_cmd.wen     = d_wen;
            w_new_cmd.size    = d_size;
            w_new_cmd.addr    = d_addr;
            w_new_cmd.wdata   = d_wdata;
            w_new_cmd.err     = f_illegal(d_size, d_addr);
        end else begin
            w_new_cmd.owner_d = 1'b0;
            w_new_cmd.size    = 3'd2;
            w_new_cmd.addr    = i_addr;
            w_new_cmd.err     = f_illegal(3'd2, i_addr);
        end
    end

    always_comb begin
        case (r_cmd.size)
            3'd0:    w_rd_masked = {24'd0, mem_rdata[7:0]};
            3'd1:    w_rd_masked = {16'd0, mem_rdata[15:0]};
            default: w_rd_masked = mem_rdata;
        endcase
    end

    assign w_owner_rdy = r_cmd.owner_d ? d_rsp_ready : i_rsp_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_last_d   <= 1'b1;
            r_cmd      <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_i_gnt || w_d_gnt) begin
                        r_cmd    <= w_new_cmd;
                        r_last_d <= w_d_gnt;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_err  <= r_cmd.err;
                    r_rsp_data <= (r_cmd.err || r_cmd.wen) ? 32'd0 : w_rd_masked;
                    r_state    <= S_RESP;
                end
                S_RESP: begin
                    if (w_owner_rdy)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign i_gnt = w_i_gnt;
    assign d_gnt = w_d_gnt;

    // Illegal commands never touch memory, so d_size 3..7 cannot reach mem_size.
    assign w_exec    = (r_state == S_EXEC) && !r_cmd.err;
    assign mem_en    = w_exec;
    assign mem_wen   = w_exec && r_cmd.wen;
    assign mem_addr  = w_exec ? r_cmd.addr  : '0;
    assign mem_size  = w_exec ? r_cmd.size  : '0;
    assign mem_wdata = w_exec ? r_cmd.wdata : '0;

    assign i_rsp_valid = (r_state == S_RESP) && !r_cmd.owner_d;
    assign d_rsp_valid = (r_state == S_RESP) &&  r_cmd.owner_d;
    assign i_rsp_data  = i_rsp_valid ? r_rsp_data : '0;
    assign d_rsp_data  = d_rsp_valid ? r_rsp_data : '0;
    assign i_rsp_err   = i_rsp_valid && r_rsp_err;
    assign d_rsp_err   = d_rsp_valid && r_rsp_err;

endmodule
